// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial TX byte stream between NUM_REQ framed message sources.
// Latency: grant one cycle after request; bytes then pass combinationally, one per cycle.
// Backpressure: out_ready is passed straight to the owner's req_ready; non-owners always see ready low.
//
// Optional feature macro: SERIAL_TX_ARB_TIMEOUT_EN
//   When defined, an owner that leaves req_valid low for TIMEOUT_CYCLES cycles loses the grant
//   and timeout_err pulses for one cycle. When undefined, timeout_err is tied low.
//
// Ports:
//   comm_clock, comm_reset_n   clock and asynchronous active-low reset
//   req_valid/req_data/req_last/req_ready   per-requester byte streams (lane i = req_data[8*i+:8])
//   out_valid/out_data/out_ready            merged byte stream toward the UART TX FIFO
//   grant                                   one-hot current owner, zero when idle
//   busy                                    a message is in progress
//   timeout_err                             one-cycle pulse when an idle owner is revoked

module serial_tx_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   comm_clock,
   input  logic                   comm_reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   out_valid,
   output logic [7:0]             out_data,
   input  logic                   out_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_winner_q, last_winner_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;

   logic               own_vld;
   logic               own_last;
   logic [7:0]         own_dat;
   logic               xfer;
   logic               timeout_hit;

   // ------------------------------------------------------------------
   // Round-robin pick: search upward from last_winner+1, wrapping.
   // Constant lane indices keep every select static; the priority chain
   // is resolved by the pick_found flag rather than an early exit.
   // ------------------------------------------------------------------
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req_valid[i] &&
                (i == ((int'(last_winner_q) + k) % NUM_REQ))) begin
               pick_found = 1'b1;
               pick_idx   = IDX_W'(i);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Owner lane select
   // ------------------------------------------------------------------
   always_comb begin
      own_vld  = 1'b0;
      own_last = 1'b0;
      own_dat  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            own_vld  = req_valid[i];
            own_last = req_last[i];
            own_dat  = req_data[8*i +: 8];
         end
      end
   end

   assign xfer = (state_q == GRANT) && own_vld && out_ready;

   // ------------------------------------------------------------------
   // Pass-through datapath: only the owner ever sees ready, and only in GRANT.
   // ------------------------------------------------------------------
   always_comb begin
      req_ready = '0;
      out_valid = 1'b0;
      out_data  = '0;
      if (state_q == GRANT) begin
         out_valid = own_vld;
         out_data  = own_dat;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
               req_ready[i] = out_ready;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Optional idle-owner timeout
   // ------------------------------------------------------------------
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

   // A byte accepted in the same cycle the limit is reached wins: the
   // owner is clearly alive again, so no byte is dropped by a revoke.
   assign timeout_hit = (state_q == GRANT) && !xfer &&
                        (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (state_q != GRANT) begin
         // Held at zero in IDLE, so every entry to GRANT starts from zero.
         idle_cnt_d = '0;
      end else if (xfer || timeout_hit) begin
         idle_cnt_d = '0;
      end else if (!own_vld) begin
         // Stalls with valid high (out_ready low) do not count.
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge comm_clock or negedge comm_reset_n) begin
      if (!comm_reset_n) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign timeout_err = timeout_hit;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      owner_d       = owner_q;
      last_winner_d = last_winner_q;
      if (state_q == IDLE) begin
         if (pick_found) begin
            state_d = GRANT;
            owner_d = pick_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
               grant_d[i] = (pick_idx == IDX_W'(i));
            end
         end
      end else begin
         // Grant is released only on the accepted last byte (or a timeout);
         // returning through IDLE guarantees a gap cycle between messages.
         if ((xfer && own_last) || timeout_hit) begin
            state_d       = IDLE;
            grant_d       = '0;
            last_winner_d = owner_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge comm_clock or negedge comm_reset_n) begin
      if (!comm_reset_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         owner_q       <= '0;
         // Starting at the top index makes requester 0 the first winner.
         last_winner_q <= LAST_IDX;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         owner_q       <= owner_d;
         last_winner_q <= last_winner_d;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with three requesters.
// Each scenario runs a fixed number of cycles from a small stimulus plan and
// compares recorded outputs against hand-computed per-cycle expectations.
`timescale 1ns/1ps

module tb_serial_tx_arbiter;

   localparam int NR = 3;

   logic               comm_clock = 1'b0;
   logic               comm_reset_n = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [8*NR-1:0]    req_data = '0;
   logic [NR-1:0]      req_last = '0;
   logic [NR-1:0]      req_ready;
   logic               out_valid;
   logic [7:0]         out_data;
   logic               out_ready = 1'b1;
   logic [NR-1:0]      grant;
   logic               busy;
   logic               timeout_err;

   int checks = 0;
   int failures = 0;

   serial_tx_arbiter #(
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .comm_clock   (comm_clock),
      .comm_reset_n (comm_reset_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .grant        (grant),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 comm_clock = ~comm_clock;

   // stimulus plan
   logic [7:0] msg [NR][8];
   int         msg_len [NR];
   int         start_c [NR];
   int         pause_c [NR];
   int         pause_n [NR];
   logic       rdy_pat [32];
   int         rdy_n;

   // per-cycle record
   logic [NR-1:0] r_gr [32];
   logic [NR-1:0] r_rr [32];
   logic          r_ov [32];
   logic          r_busy [32];
   logic          r_te [32];
   logic [7:0]    r_od [32];
   logic [7:0]    acc_b [32];
   int            acc_c [32];
   int            acc_n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge comm_clock);
      #1;
   endtask

   task automatic clear_plan();
      for (int i = 0; i < NR; i++) begin
         msg_len[i] = 0;
         start_c[i] = 0;
         pause_c[i] = 0;
         pause_n[i] = 0;
         for (int j = 0; j < 8; j++) msg[i][j] = 8'h00;
      end
      rdy_n = 0;
      for (int c = 0; c < 32; c++) begin
         rdy_pat[c] = 1'b1;
         r_gr[c] = '0; r_rr[c] = '0; r_ov[c] = 1'b0;
         r_busy[c] = 1'b0; r_te[c] = 1'b0; r_od[c] = 8'h00;
         acc_b[c] = 8'h00; acc_c[c] = -1;
      end
      acc_n = 0;
   endtask

   task automatic do_reset();
      req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
      comm_reset_n = 1'b0;
      step();
      step();
      comm_reset_n = 1'b1;
   endtask

   // Drive the plan for n cycles; cycle 0 is the first cycle requests may appear.
   task automatic run(input int n);
      int ptr [NR];
      for (int i = 0; i < NR; i++) ptr[i] = 0;
      for (int c = 0; c < n; c++) begin
         step();
         req_valid = '0; req_data = '0; req_last = '0;
         for (int i = 0; i < NR; i++) begin
            if (ptr[i] < msg_len[i]) begin
               req_data[8*i +: 8] = msg[i][ptr[i]];
               req_last[i] = (ptr[i] == msg_len[i] - 1);
               if (c >= start_c[i] && !(c >= pause_c[i] && c < pause_c[i] + pause_n[i]))
                  req_valid[i] = 1'b1;
            end
         end
         out_ready = (c < rdy_n) ? rdy_pat[c] : 1'b1;
         #3;
         r_gr[c] = grant; r_rr[c] = req_ready; r_ov[c] = out_valid;
         r_busy[c] = busy; r_te[c] = timeout_err; r_od[c] = out_data;
         if (out_valid && out_ready && acc_n < 32) begin
            acc_b[acc_n] = out_data;
            acc_c[acc_n] = c;
            acc_n++;
         end
         for (int i = 0; i < NR; i++)
            if (req_valid[i] && req_ready[i]) ptr[i]++;
      end
      req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
   endtask

   initial begin
      int cnt52;
      logic [7:0] exp_b [6];
      int         exp_c [6];

      // ---------------- reset state ----------------
      #2;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_timeout_err", 32'(timeout_err), 32'h0);
      step();
      comm_reset_n = 1'b1;

      // ---------------- single 3-byte message from requester 0 ----------------
      clear_plan();
      msg[0][0] = 8'h30; msg[0][1] = 8'h31; msg[0][2] = 8'h0A; msg_len[0] = 3;
      run(6);
      check("t1_idle_grant", 32'(r_gr[0]), 32'h0);
      check("t1_idle_out_valid", 32'(r_ov[0]), 32'h0);
      check("t1_idle_ready", 32'(r_rr[0]), 32'h0);
      check("t1_grant", 32'(r_gr[1]), 32'h1);
      check("t1_byte0", 32'(r_od[1]), 32'h30);
      check("t1_ready0", 32'(r_rr[1]), 32'h1);
      check("t1_byte1", 32'(r_od[2]), 32'h31);
      check("t1_byte2", 32'(r_od[3]), 32'h0A);
      check("t1_busy_last", 32'(r_busy[3]), 32'h1);
      check("t1_busy_after", 32'(r_busy[4]), 32'h0);
      check("t1_grant_after", 32'(r_gr[4]), 32'h0);
      check("t1_acc_n", 32'(acc_n), 32'd3);
      check("t1_last_cycle", 32'(acc_c[2]), 32'd3);

      // ---------------- three simultaneous 2-byte messages ----------------
      do_reset();
      clear_plan();
      msg[0][0] = 8'hA0; msg[0][1] = 8'hA1; msg_len[0] = 2;
      msg[1][0] = 8'hB0; msg[1][1] = 8'hB1; msg_len[1] = 2;
      msg[2][0] = 8'hC0; msg[2][1] = 8'hC1; msg_len[2] = 2;
      run(10);
      exp_b[0] = 8'hA0; exp_b[1] = 8'hA1; exp_b[2] = 8'hB0;
      exp_b[3] = 8'hB1; exp_b[4] = 8'hC0; exp_b[5] = 8'hC1;
      exp_c[0] = 1; exp_c[1] = 2; exp_c[2] = 4; exp_c[3] = 5; exp_c[4] = 7; exp_c[5] = 8;
      check("t2_acc_n", 32'(acc_n), 32'd6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("t2_byte%0d", k), 32'(acc_b[k]), 32'(exp_b[k]));
         check($sformatf("t2_cycle%0d", k), 32'(acc_c[k]), 32'(exp_c[k]));
      end
      check("t2_gap1_busy", 32'(r_busy[3]), 32'h0);
      check("t2_gap2_busy", 32'(r_busy[6]), 32'h0);
      check("t2_grant_r1", 32'(r_gr[4]), 32'h2);
      check("t2_grant_r2", 32'(r_gr[7]), 32'h4);

      // ---------------- requester 1 with out_ready stalls ----------------
      clear_plan();
      msg[1][0] = 8'h51; msg[1][1] = 8'h52; msg[1][2] = 8'h53; msg_len[1] = 3;
      msg[0][0] = 8'h60; msg_len[0] = 1; start_c[0] = 1;
      msg[2][0] = 8'h62; msg_len[2] = 1; start_c[2] = 1;
      rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b1; rdy_pat[2] = 1'b0;
      rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b1; rdy_n = 5;
      run(12);
      check("t3_grant", 32'(r_gr[1]), 32'h2);
      check("t3_ready_c1", 32'(r_rr[1]), 32'h2);
      check("t3_hold_c2", 32'(r_od[2]), 32'h52);
      check("t3_hold_c3", 32'(r_od[3]), 32'h52);
      check("t3_ready_stall_c2", 32'(r_rr[2]), 32'h0);
      check("t3_ready_stall_c3", 32'(r_rr[3]), 32'h0);
      check("t3_ready_c4", 32'(r_rr[4]), 32'h2);
      cnt52 = 0;
      for (int k = 0; k < acc_n; k++) if (acc_b[k] == 8'h52) cnt52++;
      check("t3_once_52", 32'(cnt52), 32'd1);
      check("t3_acc_n", 32'(acc_n), 32'd5);
      check("t3_last_cycle", 32'(acc_c[2]), 32'd5);
      check("t3_next_r2", 32'(r_gr[7]), 32'h4);
      check("t3_next_r2_byte", 32'(acc_b[3]), 32'h62);
      check("t3_then_r0", 32'(r_gr[9]), 32'h1);

      // ---------------- requester 2 drops valid mid-message ----------------
      clear_plan();
      msg[2][0] = 8'hD0; msg[2][1] = 8'hD1; msg[2][2] = 8'hD2; msg[2][3] = 8'hD3;
      msg_len[2] = 4; pause_c[2] = 2; pause_n[2] = 5;
      run(12);
      check("t4_grant", 32'(r_gr[1]), 32'h4);
      check("t4_pause_grant_c4", 32'(r_gr[4]), 32'h4);
      check("t4_pause_valid_c4", 32'(r_ov[4]), 32'h0);
      check("t4_pause_grant_c6", 32'(r_gr[6]), 32'h4);
      check("t4_pause_valid_c6", 32'(r_ov[6]), 32'h0);
      check("t4_resume", 32'(r_od[7]), 32'hD1);
      check("t4_last", 32'(r_od[9]), 32'hD3);
      check("t4_busy_after", 32'(r_busy[10]), 32'h0);
      check("t4_acc_n", 32'(acc_n), 32'd4);

      // ---------------- reset asserted mid-message ----------------
      step();
      req_valid = 3'b010; req_data = '0; req_data[15:8] = 8'h81; req_last = '0; out_ready = 1'b1;
      #3;
      check("t5_idle", 32'(grant), 32'h0);
      step();
      #3;
      check("t5_grant", 32'(grant), 32'h2);
      check("t5_byte0", 32'(out_data), 32'h81);
      step();
      req_data[15:8] = 8'h82;
      #1;
      comm_reset_n = 1'b0;
      #1;
      check("t5_rst_grant", 32'(grant), 32'h0);
      check("t5_rst_busy", 32'(busy), 32'h0);
      check("t5_rst_out_valid", 32'(out_valid), 32'h0);
      check("t5_rst_out_data", 32'(out_data), 32'h0);
      check("t5_rst_ready", 32'(req_ready), 32'h0);
      step();
      comm_reset_n = 1'b1;
      req_valid = 3'b011; req_data = '0;
      req_data[7:0] = 8'h90; req_data[15:8] = 8'h81; req_last = 3'b011;
      #3;
      check("t5_post_idle", 32'(grant), 32'h0);
      step();
      #3;
      check("t5_post_grant", 32'(grant), 32'h1);
      check("t5_post_byte", 32'(out_data), 32'h90);
      step();
      req_valid = '0; req_data = '0; req_last = '0;
      step();

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
      // ---------------- idle owner timeout ----------------
      do_reset();
      clear_plan();
      msg[1][0] = 8'hE0; msg[1][1] = 8'hE1; msg_len[1] = 2; pause_c[1] = 2; pause_n[1] = 20;
      msg[2][0] = 8'hF0; msg_len[2] = 1; start_c[2] = 2;
      run(14);
      check("t6_grant", 32'(r_gr[1]), 32'h2);
      check("t6_no_early_err", 32'(r_te[9]), 32'h0);
      check("t6_err_pulse", 32'(r_te[10]), 32'h1);
      check("t6_err_one_cycle", 32'(r_te[11]), 32'h0);
      check("t6_grant_held", 32'(r_gr[10]), 32'h2);
      check("t6_revoked", 32'(r_gr[11]), 32'h0);
      check("t6_r2_ignored", 32'(r_rr[5]), 32'h0);
      check("t6_r2_granted", 32'(r_gr[12]), 32'h4);
      check("t6_r2_byte", 32'(r_od[12]), 32'hF0);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
